median3_stream: RTL

Streaming 1D median-of-3 filter stage: takes one unsigned sample per valid cycle, keeps a 3-sample sliding window, and emits the median of each full window through a 2-stage compare pipeline. It sits between the sample source and the output register bank of the median filter datapath. Frame boundaries are marked with `in_last`, which re-primes the window so medians never straddle frames.

---
 rtl/median_pkg.sv | 13 +
 rtl/minmax2.sv | 26 ++
 rtl/median3_stream.sv | 105 ++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// +---------------------------------------------------------------------------+
// | median_pkg : shared constants for the median-of-3 stream filter.          |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

package median_pkg;
  localparam int WIN       = 3;
  localparam int DEF_WIDTH = 8;
  localparam int FILL_W    = 2;
endpackage : median_pkg

`default_nettype wire

// File: rtl/minmax2.sv
// +---------------------------------------------------------------------------+
// | minmax2  : combinational unsigned compare-exchange (a, b -> lo, hi).      |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
`default_nettype none

module minmax2
  import median_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic w_a_lt_b;

  assign w_a_lt_b = (a < b);
  assign lo       = w_a_lt_b ? a : b;
  assign hi       = w_a_lt_b ? b : a;

endmodule : minmax2

`default_nettype wire

// File: rtl/median3_stream.sv
// +---------------------------------------------------------------------------+
// | median3_stream : streaming median-of-3 with frame re-priming on in_last,  |
// |                  2-stage compare pipeline.                                |
// | Revision       : 1.0                                                      |
// +---------------------------------------------------------------------------+
`default_nettype none

module median3_stream
  import median_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  logic [WIDTH-1:0]  r_w0;
  logic [WIDTH-1:0]  r_w1;
  logic [FILL_W-1:0] r_fill;
  logic              w_full;

  logic [WIDTH-1:0]  w_lo;
  logic [WIDTH-1:0]  w_hi;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_c;
  logic              r_v1;
  logic              r_l1;

  logic [WIDTH-1:0]  w_min_hc;
  logic [WIDTH-1:0]  w_max_hc_unused;
  logic [WIDTH-1:0]  w_med;

  assign w_full = (r_fill == FILL_W'(WIN - 1));

  minmax2 #(.WIDTH(WIDTH)) u_mm_in (
    .a  (in_data),
    .b  (r_w0),
    .lo (w_lo),
    .hi (w_hi)
  );

  minmax2 #(.WIDTH(WIDTH)) u_mm_hc (
    .a  (r_hi),
    .b  (r_c),
    .lo (w_min_hc),
    .hi (w_max_hc_unused)
  );

  assign w_med = (r_lo > w_min_hc) ? r_lo : w_min_hc;

  // Window and fill counter; in_last re-primes so no median spans two frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w0   <= '0;
      r_w1   <= '0;
      r_fill <= '0;
    end else if (in_valid) begin
      r_w1 <= r_w0;
      r_w0 <= in_data;
      if (in_last) begin
        r_fill <= '0;
      end else if (!w_full) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo <= '0;
      r_hi <= '0;
      r_c  <= '0;
      r_v1 <= 1'b0;
      r_l1 <= 1'b0;
    end else begin
      r_lo <= w_lo;
      r_hi <= w_hi;
      r_c  <= r_w1;
      r_v1 <= in_valid && w_full;
      r_l1 <= in_valid && in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= r_v1;
      out_data  <= w_med;
      out_last  <= r_l1 && r_v1;
    end
  end

endmodule : median3_stream

`default_nettype wire
